// File: rtl/mdu_sequencer_if.sv
// Pipeline <-> multiply/divide sequencer bundle: request, HI/LO write port,
// status and the HI/LO architectural registers.
interface mdu_if #(
    parameter int WIDTH = 32
) ();
    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] src0;
    logic [WIDTH-1:0] src1;
    logic [1:0]       hilo_we;
    logic [WIDTH-1:0] hilo_wdata;
    logic             busy;
    logic             done;
    logic             div_by_zero;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output start, op, src0, src1, hilo_we, hilo_wdata,
        input  busy, done, div_by_zero, hi, lo
    );

    modport slave (
        input  start, op, src0, src1, hilo_we, hilo_wdata,
        output busy, done, div_by_zero, hi, lo
    );
endinterface

// File: rtl/mdu_sequencer.sv
// Radix-2 multi-cycle MULT/MULTU/DIV/DIVU sequencer owning HI/LO.
// Define MDU_DIV_EN to build the divide datapath; otherwise divides complete immediately.
module mdu_sequencer #(
    parameter int WIDTH = 32
) (
    input logic clk,
    input logic rst,
    mdu_if.slave bus
);
    localparam int CW = $clog2(WIDTH) + 1;

    typedef enum logic [2:0] {IDLE, PREP, ITER, FIX, DONE} state_t;

    state_t             state;
    logic [CW-1:0]      cnt;
    logic [WIDTH-1:0]   a_r, b_r;
    logic [2*WIDTH-1:0] acc, mcand;
    logic               signed_op, neg_p;
    logic               busy_r, done_r, dbz_r;
    logic [WIDTH-1:0]   hi_r, lo_r;
    logic [WIDTH-1:0]   a_abs, b_abs;

    assign a_abs = (signed_op && a_r[WIDTH-1]) ? -a_r : a_r;
    assign b_abs = (signed_op && b_r[WIDTH-1]) ? -b_r : b_r;

`ifdef MDU_DIV_EN
    logic             is_div, neg_r;
    logic [WIDTH:0]   shifted, diff;

    // acc holds {remainder, quotient}; quotient bits shift in from the bottom
    assign shifted = acc[2*WIDTH-1:WIDTH-1];
    assign diff    = shifted - {1'b0, b_r};
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            a_r       <= '0;
            b_r       <= '0;
            acc       <= '0;
            mcand     <= '0;
            signed_op <= 1'b0;
            neg_p     <= 1'b0;
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
            dbz_r     <= 1'b0;
            hi_r      <= '0;
            lo_r      <= '0;
`ifdef MDU_DIV_EN
            is_div    <= 1'b0;
            neg_r     <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE, DONE: begin
                    done_r <= 1'b0;
                    dbz_r  <= 1'b0;
                    if (bus.start) begin
                        a_r       <= bus.src0;
                        b_r       <= bus.src1;
                        signed_op <= ~bus.op[0];
`ifdef MDU_DIV_EN
                        is_div    <= bus.op[1];
                        busy_r    <= 1'b1;
                        state     <= PREP;
`else
                        if (bus.op[1]) begin
                            done_r <= 1'b1;
                            state  <= DONE;
                        end else begin
                            busy_r <= 1'b1;
                            state  <= PREP;
                        end
`endif
                    end else begin
                        state <= IDLE;
                        if (bus.hilo_we[1]) hi_r <= bus.hilo_wdata;
                        if (bus.hilo_we[0]) lo_r <= bus.hilo_wdata;
                    end
                end

                PREP: begin
                    neg_p <= signed_op & (a_r[WIDTH-1] ^ b_r[WIDTH-1]);
                    cnt   <= '0;
`ifdef MDU_DIV_EN
                    neg_r <= signed_op & a_r[WIDTH-1];
                    if (is_div) begin
                        if (b_r == '0) begin
                            hi_r   <= a_r;
                            lo_r   <= '1;
                            dbz_r  <= 1'b1;
                            done_r <= 1'b1;
                            busy_r <= 1'b0;
                            state  <= DONE;
                        end else begin
                            acc   <= {{WIDTH{1'b0}}, a_abs};
                            b_r   <= b_abs;
                            state <= ITER;
                        end
                    end else
`endif
                    begin
                        acc   <= '0;
                        mcand <= {{WIDTH{1'b0}}, a_abs};
                        b_r   <= b_abs;
                        state <= ITER;
                    end
                end

                ITER: begin
`ifdef MDU_DIV_EN
                    if (is_div)
                        acc <= {(diff[WIDTH] ? shifted[WIDTH-1:0] : diff[WIDTH-1:0]),
                                acc[WIDTH-2:0], ~diff[WIDTH]};
                    else
`endif
                    begin
                        if (b_r[0]) acc <= acc + mcand;
                        mcand <= {mcand[2*WIDTH-2:0], 1'b0};
                        b_r   <= {1'b0, b_r[WIDTH-1:1]};
                    end
                    cnt <= cnt + CW'(1);
                    if (cnt == CW'(WIDTH - 1)) state <= FIX;
                end

                FIX: begin
                    busy_r <= 1'b0;
                    done_r <= 1'b1;
                    state  <= DONE;
`ifdef MDU_DIV_EN
                    if (is_div) begin
                        lo_r <= neg_p ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
                        hi_r <= neg_r ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
                    end else
`endif
                    {hi_r, lo_r} <= neg_p ? -acc : acc;
                end

                default: state <= IDLE;
            endcase
        end
    end

    assign bus.busy        = busy_r;
    assign bus.done        = done_r;
    assign bus.div_by_zero = dbz_r;
    assign bus.hi          = hi_r;
    assign bus.lo          = lo_r;
endmodule

// File: tb/tb_mdu_sequencer.sv
// Randomized self-checking bench for mdu_sequencer against an arithmetic model;
// follows MDU_DIV_EN so divide expectations match the build.
module tb_mdu_sequencer;
    localparam int W = 32;
`ifdef MDU_DIV_EN
    localparam bit DIV_EN = 1'b1;
`else
    localparam bit DIV_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    mdu_if #(.WIDTH(W)) bus ();

    mdu_sequencer #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_checks = 0;
    int n_errors = 0;
    logic [W-1:0] m_hi = '0;
    logic [W-1:0] m_lo = '0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // {div_by_zero, hi, lo} from the architectural definition of each op
    function automatic logic [64:0] ref_result(input logic [1:0] op, input logic [31:0] a,
                                               input logic [31:0] b, input logic [31:0] hi0,
                                               input logic [31:0] lo0);
        logic [63:0] p;
        int q, r;
        case (op)
            2'd0: p = 64'(longint'($signed(a)) * longint'($signed(b)));
            2'd1: p = 64'(a) * 64'(b);
            default: begin
                if (!DIV_EN) return {1'b0, hi0, lo0};
                if (b == 32'd0) return {1'b1, a, 32'hFFFF_FFFF};
                if (op == 2'd2) begin
                    if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF)
                        return {1'b0, 32'h0, 32'h8000_0000};
                    q = $signed(a) / $signed(b);
                    r = $signed(a) % $signed(b);
                    return {1'b0, 32'(r), 32'(q)};
                end
                return {1'b0, a % b, a / b};
            end
        endcase
        return {1'b0, p};
    endfunction

    function automatic int ref_latency(input logic [1:0] op, input logic [31:0] b);
        if (!op[1]) return 34;
        if (!DIV_EN) return 0;
        if (b == 32'd0) return 1;
        return 34;
    endfunction

    task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                          input bit interfere, input bit chain);
        logic [64:0] exp;
        int lat, busy_n, seen_k;
        bit seen;
        exp = ref_result(op, a, b, m_hi, m_lo);
        lat = ref_latency(op, b);
        @(negedge clk);
        bus.start      = 1'b1;
        bus.op         = op;
        bus.src0       = a;
        bus.src1       = b;
        bus.hilo_we    = 2'b11;
        bus.hilo_wdata = $urandom;
        @(posedge clk);
        #1;
        bus.start   = 1'b0;
        bus.hilo_we = 2'b00;
        check("start_beats_we_hi", 64'(bus.hi), 64'(m_hi));
        check("start_beats_we_lo", 64'(bus.lo), 64'(m_lo));
        seen = 1'b0;
        seen_k = -1;
        busy_n = 0;
        for (int k = 0; k < 60; k++) begin
            if (bus.done) begin
                seen = 1'b1;
                seen_k = k;
                break;
            end
            if (bus.busy) busy_n++;
            if (interfere) begin
                case (k)
                    10: begin
                        bus.start = 1'b1;
                        bus.op    = 2'($urandom_range(0, 3));
                        bus.src0  = $urandom;
                        bus.src1  = $urandom;
                    end
                    11: bus.start = 1'b0;
                    12: begin
                        bus.hilo_we    = 2'b11;
                        bus.hilo_wdata = $urandom;
                    end
                    13: bus.hilo_we = 2'b00;
                    default: ;
                endcase
            end
            @(posedge clk);
            #1;
        end
        check("done_seen", 64'(seen), 64'(1));
        if (seen) begin
            check("done_latency", 64'(seen_k), 64'(lat));
            check("busy_cycles", 64'(busy_n), 64'(lat));
            check("busy_in_done", 64'(bus.busy), 64'(0));
            check("hi", 64'(bus.hi), 64'(exp[63:32]));
            check("lo", 64'(bus.lo), 64'(exp[31:0]));
            check("div_by_zero", 64'(bus.div_by_zero), 64'(exp[64]));
            m_hi = exp[63:32];
            m_lo = exp[31:0];
        end
        if (!chain) begin
            @(posedge clk);
            #1;
            check("done_single_pulse", 64'(bus.done), 64'(0));
        end
    endtask

    task automatic hilo_write(input logic [1:0] we, input logic [31:0] d);
        @(negedge clk);
        bus.hilo_we    = we;
        bus.hilo_wdata = d;
        @(posedge clk);
        #1;
        bus.hilo_we = 2'b00;
        if (we[1]) m_hi = d;
        if (we[0]) m_lo = d;
        check("mt_hi", 64'(bus.hi), 64'(m_hi));
        check("mt_lo", 64'(bus.lo), 64'(m_lo));
    endtask

    initial begin
        logic [1:0]  rop;
        logic [31:0] ra, rb;
        bit          stray_done;

        bus.start = 1'b0;
        bus.op = 2'b00;
        bus.src0 = '0;
        bus.src1 = '0;
        bus.hilo_we = 2'b00;
        bus.hilo_wdata = '0;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy", 64'(bus.busy), 64'(0));
        check("rst_done", 64'(bus.done), 64'(0));
        check("rst_dbz", 64'(bus.div_by_zero), 64'(0));
        check("rst_hi", 64'(bus.hi), 64'(0));
        check("rst_lo", 64'(bus.lo), 64'(0));
        @(negedge clk);
        rst = 1'b0;

        hilo_write(2'b01, 32'h0000_1234);
        hilo_write(2'b10, 32'hCAFE_F00D);

        run_op(2'd0, 32'hFFFF_FFFD, 32'd5, 1'b1, 1'b0);
        run_op(2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b0);
        run_op(2'd2, 32'hFFFF_FFF9, 32'd2, 1'b0, 1'b0);
        run_op(2'd3, 32'd100, 32'd7, 1'b0, 1'b0);
        run_op(2'd3, 32'd7, 32'd0, 1'b0, 1'b1);
        run_op(2'd2, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b1);
        run_op(2'd0, 32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0);

        for (int i = 0; i < 40; i++) begin
            rop = 2'($urandom_range(0, 3));
            ra = ($urandom_range(0, 7) == 0) ? 32'h8000_0000 : $urandom;
            case ($urandom_range(0, 7))
                0: rb = 32'd0;
                1: rb = 32'($urandom_range(1, 15));
                2: rb = 32'hFFFF_FFFF;
                default: rb = $urandom;
            endcase
            run_op(rop, ra, rb, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end

        // abort an in-flight op with reset
        @(negedge clk);
        bus.start = 1'b1;
        bus.op    = DIV_EN ? 2'd2 : 2'd0;
        bus.src0  = $urandom;
        bus.src1  = 32'd3;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        repeat (19) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("abort_busy", 64'(bus.busy), 64'(0));
        check("abort_done", 64'(bus.done), 64'(0));
        check("abort_hi", 64'(bus.hi), 64'(0));
        check("abort_lo", 64'(bus.lo), 64'(0));
        m_hi = '0;
        m_lo = '0;
        stray_done = 1'b0;
        for (int k = 0; k < 40; k++) begin
            if (bus.done || bus.busy) stray_done = 1'b1;
            @(posedge clk);
            #1;
        end
        check("abort_no_done", 64'(stray_done), 64'(0));

        hilo_write(2'b01, 32'h0000_1234);
        run_op(2'd1, $urandom, $urandom, 1'b0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
